sram_controller: RTL

SRAM_CONTROLLER -- requirements
Module: sram_controller

---
 rtl/sram_controller.sv | 122 ++++++++++++
 1 files changed

// File: rtl/sram_controller.sv
// Bridges 32-bit pipeline loads/stores to a 16-bit asynchronous SRAM as two
// timed half-accesses (low half, then high half), freezing the pipeline via ready.
module sram_controller #(
  parameter int WAIT_CYCLES = 2,
  parameter int BASE_ADDR   = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  input  logic [15:0] sram_dq_in,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  output logic        sram_we_n
);

  // state  | meaning
  // IDLE   | no access in flight; accept rd_en/wr_en
  // LOW    | low halfword access, held WAIT_CYCLES cycles
  // HIGH   | high halfword access, held WAIT_CYCLES cycles
  // DONE   | single-cycle completion, ready=1
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOW  = 2'd1;
  localparam logic [1:0] S_HIGH = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [3:0]  CNT_LAST = 4'(WAIT_CYCLES - 1);
  localparam logic [31:0] BASE     = 32'(BASE_ADDR);

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic        op_wr;
  logic [16:0] word;
  logic [31:0] wdata;
  logic [31:0] offset;
  logic        req;
  logic        cnt_last;
  logic        unused_bits;

  assign offset      = address - BASE;
  assign req         = rd_en | wr_en;
  assign cnt_last    = (cnt == CNT_LAST);
  // Byte-lane bits and the part of the offset beyond the SRAM window are ignored.
  assign unused_bits = ^{offset[31:19], offset[1:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      op_wr     <= 1'b0;
      word      <= 17'd0;
      wdata     <= 32'd0;
      read_data <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            word  <= offset[18:2];
            wdata <= write_data;
            op_wr <= wr_en;
            cnt   <= 4'd0;
            state <= S_LOW;
          end
        end
        S_LOW: begin
          if (cnt_last) begin
            cnt   <= 4'd0;
            state <= S_HIGH;
            if (!op_wr) read_data[15:0] <= sram_dq_in;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_HIGH: begin
          if (cnt_last) begin
            cnt   <= 4'd0;
            state <= S_DONE;
            if (!op_wr) read_data[31:16] <= sram_dq_in;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Bus outputs decode from state so a reset drops the write strobe instantly.
  always_comb begin
    sram_addr   = 18'd0;
    sram_we_n   = 1'b1;
    sram_dq_oe  = 1'b0;
    sram_dq_out = 16'd0;
    ready       = 1'b0;
    case (state)
      S_IDLE: ready = ~req;
      S_LOW: begin
        sram_addr = {word, 1'b0};
        if (op_wr) begin
          sram_we_n   = 1'b0;
          sram_dq_oe  = 1'b1;
          sram_dq_out = wdata[15:0];
        end
      end
      S_HIGH: begin
        sram_addr = {word, 1'b1};
        if (op_wr) begin
          sram_we_n   = 1'b0;
          sram_dq_oe  = 1'b1;
          sram_dq_out = wdata[31:16];
        end
      end
      default: ready = 1'b1;
    endcase
  end

endmodule
